// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with broadcast and per-channel
// saturating transfer counters. Each channel owns a one-entry output register.
module demux_stream #(
  parameter int W    = 8,
  parameter int SELW = 2,
  parameter int CNTW = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        bcast,
  input  logic                        clr_cnt,
  input  logic [W-1:0]                in_data,
  input  logic [SELW-1:0]             in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [(2**SELW)*W-1:0]      out_data,
  output logic [(2**SELW)-1:0]        out_valid,
  input  logic [(2**SELW)-1:0]        out_ready,
  output logic [(2**SELW)*CNTW-1:0]   xfer_cnt
);

  localparam int N = 2**SELW;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [N-1:0] w_valid;
  logic [N-1:0] w_free;
  logic [N-1:0] w_pop;
  logic [N-1:0] w_load;
  logic         w_accept;

  // A channel is free if empty or being drained this cycle (pop + reload allowed).
  assign w_free    = ~w_valid | out_ready;
  assign w_pop     = w_valid & out_ready;
  assign in_ready  = rst_n & en & (bcast ? (&w_free) : w_free[in_sel]);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = w_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic            r_vld;
      logic [W-1:0]    r_data;
      logic [CNTW-1:0] r_cnt;

      assign w_load[gi] = w_accept & (bcast | (in_sel == SELW'(gi)));
      assign w_valid[gi] = r_vld;
      assign out_data[gi*W +: W] = r_data;
      assign xfer_cnt[gi*CNTW +: CNTW] = r_cnt;

      // An emptied channel returns to zero data so idle outputs are clean.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld  <= 1'b0;
          r_data <= '0;
        end else if (w_load[gi]) begin
          r_vld  <= 1'b1;
          r_data <= in_data;
        end else if (w_pop[gi]) begin
          r_vld  <= 1'b0;
          r_data <= '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clr_cnt) begin
          r_cnt <= '0;
        end else if (w_pop[gi] && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule
